iicmb_wb_sequencer: RTL and testbench
=====================================

Name: iicmb_wb_sequencer

Overview:
Hardware Wishbone master that sits directly upstream of the IICMB I2C multi-bus controller and drives its CSR/DPR/CMDR registers. It converts one request (bus ID, 7-bit slave address, N data bytes streamed in) into the full register sequence, with no software in the loop: enable, Set Bus, Start, address write, data writes, Stop. It waits for command completion by polling CMDR, or by waiting on irq when enabled, and reports one completion status per request.

Parameters:
WB_ADDR_WIDTH, 2, Wishbone address width (CSR=0, DPR=1, CMDR=2, FSMR=3)
WB_DATA_WIDTH, 8, Wishbone data width
MAX_LEN, 16, maximum data bytes per request
POLL_GAP, 4, idle cycles between CMDR polls (>=1)
TIMEOUT, 65535, maximum wait cycles per command before abort
USE_IRQ, 0, 1 = wait for irq_i high before the single CMDR status read

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_bus_i  in  4  target I2C bus ID
req_addr_i  in  7  I2C slave address
req_len_i  in  $clog2(MAX_LEN)+1  data byte count, 1..MAX_LEN
wd_valid_i  in  1  write-data byte valid
wd_ready_o  out  1  write-data byte consumed when valid&ready
wd_data_i  in  8  write-data byte
done_o  out  1  one-cycle completion pulse
status_o  out  3  0 OK, 1 NAK, 2 ARB_LOST, 3 ERR, 4 TIMEOUT; held until next done_o
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
adr_o  out  WB_ADDR_WIDTH  Wishbone address
dat_o  out  WB_DATA_WIDTH  Wishbone write data
dat_i  in  WB_DATA_WIDTH  Wishbone read data
ack_i  in  1  Wishbone acknowledge
irq_i  in  1  controller interrupt request

Behaviour:
- Reset (asynchronous, takes effect immediately): every output is 0 and status_o=0. The enabled flag is cleared. An in-flight Wishbone cycle is dropped. After release the FSM is in INIT.
- Wishbone access: cyc_o, stb_o, we_o, adr_o and dat_o assert together and are held stable until ack_i is sampled high. All are deasserted in the next cycle. Read data is captured on the ack cycle. Back-to-back accesses are separated by at least one idle cycle. The sequencer issues only single, non-pipelined accesses.
- FSM states: INIT -> IDLE -> SETBUS -> START -> ADDR -> DATA -> STOP -> FIN. Each command state contains WR_DPR (if needed), WR_CMDR, and WAIT.
- INIT: write CSR=0xC0 once, set the enabled flag, go to IDLE.
- IDLE: req_ready_o=1. On accept, latch bus, addr and len (len=0 is treated as 1); req_ready_o drops the next cycle.
- SETBUS: DPR=bus, CMDR=0x06.
- START: CMDR=0x04.
- ADDR: DPR={addr,1'b0}, CMDR=0x01.
- DATA: wd_ready_o=1 for exactly one cycle per byte, only while in WR_DPR and before the DPR access starts. The FSM stalls while wd_valid_i=0. Each byte produces DPR=byte, CMDR=0x01. The loop repeats len times.
- STOP: CMDR=0x05.
- FIN: done_o=1 for one cycle, status_o updated, return to IDLE.
- WAIT, USE_IRQ=0: read CMDR, then wait POLL_GAP cycles, and repeat until bits[7:4]!=0.
- WAIT, USE_IRQ=1: wait for irq_i=1, then read CMDR once.
- Completion decode (priority AL > ERR > NAK > DON):
  - DON: advance to the next state.
  - NAK during ADDR or DATA: status 1, jump to STOP, then FIN. Remaining data bytes are not consumed.
  - NAK during SETBUS, START or STOP is treated as ERR.
  - AL: status 2, go to FIN with no Stop.
  - ERR: status 3, go to FIN.
- Timeout: a per-WAIT counter starts at WR_CMDR ack. If it reaches TIMEOUT, status 4 and go to FIN immediately. No further bus accesses are made.
- Simultaneous req_valid_i and done_o: the request is not accepted until the cycle after FIN.

Test Plan:
- Reset release, USE_IRQ=0, req bus=5 addr=0x22 len=2 data 0x44,0x78, DUT model ACKs -> exact access order:
  - W0=C0, W1=05, W2=06, W2=04, W1=44, W2=01, W1=44, W2=01, W1=78, W2=01, W2=05
  - done_o pulse, status_o=0, wd_ready_o pulsed exactly twice.
- Same request, slave NAKs the address -> W2=05 after the address write, no data byte consumed, status_o=1.
- CMDR read returns 0x20 after Start -> no Stop issued, status_o=2, the next request is accepted and does not rewrite CSR.
- CMDR never completes, TIMEOUT=50 -> done_o about 50 cycles after the Start ack, status_o=4.
- wd_valid_i low 20 cycles mid-stream, ack_i delayed 3 cycles -> outputs held stable until ack, no duplicate writes, correct data order.
- rst_n_i asserted while stb_o=1 -> cyc_o and stb_o drop in the same cycle, and after release the sequencer rewrites CSR=0xC0 before the next request.

Source files
------------

// File: rtl/iicmb_wb_sequencer_if.sv
// Wishbone master/slave bundle between the request sequencer and the IICMB controller.
interface iicmb_wb_sequencer_if #(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8
);
    logic                     cyc_o;
    logic                     stb_o;
    logic                     we_o;
    logic [WB_ADDR_WIDTH-1:0] adr_o;
    logic [WB_DATA_WIDTH-1:0] dat_o;
    logic [WB_DATA_WIDTH-1:0] dat_i;
    logic                     ack_i;
    logic                     irq_i;

    modport master (output cyc_o, stb_o, we_o, adr_o, dat_o, input dat_i, ack_i, irq_i);
    modport slave  (input cyc_o, stb_o, we_o, adr_o, dat_o, output dat_i, ack_i, irq_i);
endinterface

// File: rtl/iicmb_wb_sequencer.sv
// Hardware Wishbone master that turns one I2C write request into the full IICMB
// register sequence (enable, Set Bus, Start, address, data, Stop) and reports a status.
module iicmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8,
    parameter int MAX_LEN       = 16,
    parameter int POLL_GAP      = 4,
    parameter int TIMEOUT       = 65535,
    parameter int USE_IRQ       = 0,
    localparam int LEN_W        = $clog2(MAX_LEN) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [3:0]            req_bus_i,
    input  logic [6:0]            req_addr_i,
    input  logic [LEN_W-1:0]      req_len_i,
    input  logic                  wd_valid_i,
    output logic                  wd_ready_o,
    input  logic [7:0]            wd_data_i,
    output logic                  done_o,
    output logic [2:0]            status_o,
    iicmb_wb_sequencer_if.master  wb
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);
    localparam logic [2:0] ST_OK = 3'd0, ST_NAK = 3'd1, ST_AL = 3'd2, ST_ERR = 3'd3, ST_TMO = 3'd4;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_SETBUS, S_START, S_ADDR, S_DATA, S_STOP, S_FIN} state_t;
    typedef enum logic [2:0] {P_DPR, P_CMDR, P_POLL, P_GAP, P_IRQ} phase_t;

    state_t                   state_q, state_d;
    phase_t                   phase_q, phase_d;
    logic                     enabled_q, enabled_d;
    logic [3:0]               bus_q, bus_d;
    logic [6:0]               addr_q, addr_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               pend_q, pend_d;
    logic [2:0]               status_q, status_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic                     cyc_q, cyc_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;

    logic                     launch, l_we, ack, timed_out, abort;
    logic [WB_ADDR_WIDTH-1:0] l_adr;
    logic [WB_DATA_WIDTH-1:0] l_dat;
    logic [2:0]               abort_code;
    logic [3:0]               flags;

    function automatic logic [7:0] cmd_code(input state_t s);
        case (s)
            S_SETBUS: cmd_code = 8'h06;
            S_START:  cmd_code = 8'h04;
            S_STOP:   cmd_code = 8'h05;
            default:  cmd_code = 8'h01;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;   phase_d = phase_q;   enabled_d = enabled_q;
        bus_d = bus_q;       addr_d = addr_q;     cnt_d = cnt_q;
        pend_d = pend_q;     status_d = status_q; tmo_d = tmo_q;   gap_d = gap_q;
        cyc_d = cyc_q;       we_d = we_q;         adr_d = adr_q;   dat_d = dat_q;
        launch = 1'b0;       l_we = 1'b1;         l_adr = ADR_DPR; l_dat = '0;
        abort = 1'b0;        abort_code = ST_OK;
        ack       = cyc_q & wb.ack_i;
        timed_out = (tmo_q >= TMO_W'(TIMEOUT));
        flags     = wb.dat_i[7:4];   // {DON, NAK, AL, ERR}

        if (ack) begin
            cyc_d = 1'b0; we_d = 1'b0; adr_d = '0; dat_d = '0;
        end
        if ((phase_q == P_POLL || phase_q == P_GAP || phase_q == P_IRQ) && !timed_out)
            tmo_d = tmo_q + 1'b1;

        case (state_q)
            S_INIT: begin
                if (!cyc_q) begin
                    launch = 1'b1; l_adr = ADR_CSR; l_dat = WB_DATA_WIDTH'(8'hC0);
                end else if (ack) begin
                    enabled_d = 1'b1; state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid_i && enabled_q) begin
                    bus_d   = req_bus_i;
                    addr_d  = req_addr_i;
                    cnt_d   = (req_len_i == '0) ? LEN_W'(1) : req_len_i;
                    pend_d  = ST_OK;
                    state_d = S_SETBUS;
                    phase_d = P_DPR;
                end
            end
            S_FIN: begin
                state_d = S_IDLE; phase_d = P_DPR;
            end
            default: begin
                case (phase_q)
                    P_DPR: begin
                        if (!cyc_q) begin
                            if (state_q == S_DATA) begin
                                launch = wd_valid_i; l_dat = WB_DATA_WIDTH'(wd_data_i);
                            end else begin
                                launch = 1'b1;
                                l_dat  = (state_q == S_SETBUS) ? WB_DATA_WIDTH'({4'b0, bus_q})
                                                               : WB_DATA_WIDTH'({addr_q, 1'b0});
                            end
                        end else if (ack) begin
                            phase_d = P_CMDR;
                        end
                    end
                    P_CMDR: begin
                        if (!cyc_q) begin
                            launch = 1'b1; l_adr = ADR_CMDR; l_dat = WB_DATA_WIDTH'(cmd_code(state_q));
                        end else if (ack) begin
                            tmo_d   = '0;
                            phase_d = (USE_IRQ != 0) ? P_IRQ : P_POLL;
                        end
                    end
                    P_IRQ: begin
                        if (timed_out) begin
                            abort = 1'b1; abort_code = ST_TMO;
                        end else if (wb.irq_i) begin
                            phase_d = P_POLL;
                        end
                    end
                    P_GAP: begin
                        if (timed_out) begin
                            abort = 1'b1; abort_code = ST_TMO;
                        end else if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                            launch = 1'b1; l_we = 1'b0; l_adr = ADR_CMDR; phase_d = P_POLL;
                        end else begin
                            gap_d = gap_q + 1'b1;
                        end
                    end
                    default: begin  // P_POLL: one CMDR status read, decoded on its ack
                        if (!cyc_q) begin
                            if (timed_out) begin
                                abort = 1'b1; abort_code = ST_TMO;
                            end else begin
                                launch = 1'b1; l_we = 1'b0; l_adr = ADR_CMDR;
                            end
                        end else if (ack) begin
                            if (flags == 4'd0) begin
                                phase_d = (USE_IRQ != 0) ? P_IRQ : P_GAP;
                                gap_d   = '0;
                            end else if (flags[1]) begin
                                abort = 1'b1; abort_code = ST_AL;
                            end else if (flags[0]) begin
                                abort = 1'b1; abort_code = ST_ERR;
                            end else if (flags[2]) begin
                                if (state_q == S_ADDR || state_q == S_DATA) begin
                                    pend_d = ST_NAK; state_d = S_STOP; phase_d = P_CMDR;
                                end else begin
                                    abort = 1'b1; abort_code = ST_ERR;
                                end
                            end else begin
                                case (state_q)
                                    S_SETBUS: begin state_d = S_START; phase_d = P_CMDR; end
                                    S_START:  begin state_d = S_ADDR;  phase_d = P_DPR;  end
                                    S_ADDR:   begin state_d = S_DATA;  phase_d = P_DPR;  end
                                    S_DATA: begin
                                        if (cnt_q <= LEN_W'(1)) begin
                                            state_d = S_STOP; phase_d = P_CMDR;
                                        end else begin
                                            cnt_d = cnt_q - 1'b1; phase_d = P_DPR;
                                        end
                                    end
                                    default: begin state_d = S_FIN; status_d = pend_q; end
                                endcase
                            end
                        end
                    end
                endcase
            end
        endcase

        // Abort paths skip Stop and finish without touching the bus again
        if (abort) begin
            state_d = S_FIN; phase_d = P_DPR; status_d = abort_code;
        end
        if (launch) begin
            cyc_d = 1'b1; we_d = l_we; adr_d = l_adr; dat_d = l_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_INIT;  phase_q <= P_DPR;  enabled_q <= 1'b0;
            bus_q <= '0;        addr_q <= '0;      cnt_q <= '0;
            pend_q <= '0;       status_q <= '0;    tmo_q <= '0;   gap_q <= '0;
            cyc_q <= 1'b0;      we_q <= 1'b0;      adr_q <= '0;   dat_q <= '0;
        end else begin
            state_q <= state_d; phase_q <= phase_d; enabled_q <= enabled_d;
            bus_q <= bus_d;     addr_q <= addr_d;   cnt_q <= cnt_d;
            pend_q <= pend_d;   status_q <= status_d; tmo_q <= tmo_d; gap_q <= gap_d;
            cyc_q <= cyc_d;     we_q <= we_d;       adr_q <= adr_d; dat_q <= dat_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE) && enabled_q;
    assign wd_ready_o  = (state_q == S_DATA) && (phase_q == P_DPR) && !cyc_q;
    assign done_o      = (state_q == S_FIN);
    assign status_o    = status_q;
    assign wb.cyc_o    = cyc_q;
    assign wb.stb_o    = cyc_q;
    assign wb.we_o     = we_q;
    assign wb.adr_o    = adr_q;
    assign wb.dat_o    = dat_q;
endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
// Directed bench for iicmb_wb_sequencer: Wishbone slave model plus a write scoreboard.
module tb_iicmb_wb_sequencer;
    logic       clk, rst_n;
    logic       req_valid, req_ready, wd_valid, wd_ready, done;
    logic [3:0] req_bus;
    logic [6:0] req_addr;
    logic [4:0] req_len;
    logic [7:0] wd_data;
    logic [2:0] status;

    iicmb_wb_sequencer_if #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) wbi ();

    iicmb_wb_sequencer #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .MAX_LEN(16),
                         .POLL_GAP(4), .TIMEOUT(50), .USE_IRQ(0)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_len_i(req_len),
        .wd_valid_i(wd_valid), .wd_ready_o(wd_ready), .wd_data_i(wd_data),
        .done_o(done), .status_o(status), .wb(wbi)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [9:0] exp_q[$];          // expected writes {adr, dat}
    logic [7:0] tbytes [16];
    int ack_dly, poll_wait, nak_idx, al_idx, hang_idx, cmd_idx, polls;
    int start_ack_cyc, hs_cnt, done_cyc;
    bit feed_stop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_full(input logic [3:0] bus, input logic [6:0] addr, input int n);
        push_w(1, {4'h0, bus}); push_w(2, 8'h06); push_w(2, 8'h04);
        push_w(1, {addr, 1'b0}); push_w(2, 8'h01);
        for (int i = 0; i < n; i++) begin push_w(1, tbytes[i]); push_w(2, 8'h01); end
        push_w(2, 8'h05);
    endtask

    // Wishbone slave: acks after ack_dly wait cycles, checks hold-stability and idle gap
    task automatic slave_model();
        int wcnt = 0;
        bit ack_pend = 0, stable = 1;
        logic [10:0] snap = '0;
        logic [7:0] r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wbi.ack_i = 0; wcnt = 0; ack_pend = 0;
                continue;
            end
            if (ack_pend) begin
                ack_pend = 0; wbi.ack_i = 0; wbi.dat_i = 0;
                chk("wb_idle_after_ack", {wbi.cyc_o, wbi.stb_o}, 0);
            end else if (wbi.cyc_o && wbi.stb_o) begin
                if (wcnt == 0) begin snap = {wbi.we_o, wbi.adr_o, wbi.dat_o}; stable = 1; end
                else if ({wbi.we_o, wbi.adr_o, wbi.dat_o} !== snap) stable = 0;
                if (wcnt == ack_dly) begin
                    wcnt = 0; ack_pend = 1; wbi.ack_i = 1;
                    chk("wb_stable_until_ack", stable, 1);
                    if (snap[10]) begin
                        if (exp_q.size() == 0) chk("wb_write_extra", snap[9:0], 10'h3FF);
                        else chk("wb_write", snap[9:0], exp_q.pop_front());
                        if (snap[9:8] == 2'd2) begin
                            cmd_idx++; polls = 0;
                            if (snap[7:0] == 8'h04) start_ack_cyc = cyc_cnt;
                        end
                    end else begin
                        chk("wb_read_adr", snap[9:8], 2);
                        r = 8'h80;
                        if (cmd_idx - 1 == nak_idx) r = 8'h40;
                        if (cmd_idx - 1 == al_idx)  r = 8'h20;
                        if (polls < poll_wait || cmd_idx - 1 == hang_idx) r = 8'h00;
                        polls++;
                        wbi.dat_i = r;
                    end
                end else wcnt++;
            end
        end
    endtask

    task automatic send_req(input logic [3:0] bus, input logic [6:0] addr, input logic [4:0] len);
        int n = 0;
        @(negedge clk);
        req_bus = bus; req_addr = addr; req_len = len; req_valid = 1;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        chk("req_ready", req_ready, 1);
        @(posedge clk); #1; req_valid = 0;
        @(negedge clk);
        chk("req_ready_drop", req_ready, 0);
    endtask

    task automatic feeder(input int n, input int stall_at, input int stall_len);
        hs_cnt = 0;
        @(posedge clk); #1;
        for (int i = 0; i < n && !feed_stop; i++) begin
            if (i == stall_at) begin
                wd_valid = 0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            wd_data = tbytes[i]; wd_valid = 1;
            @(negedge clk);
            while (!wd_ready && !feed_stop) @(negedge clk);
            if (feed_stop) break;
            @(posedge clk); #1;
            hs_cnt++; wd_valid = 0;
        end
        wd_valid = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk("done_seen", done, 1);
        done_cyc = cyc_cnt;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        feed_stop = 1;
    endtask

    task automatic run_req(input logic [3:0] bus, input logic [6:0] addr, input int n,
                           input int stall_at, input int stall_len);
        cmd_idx = 0; feed_stop = 0;
        fork
            feeder(n, stall_at, stall_len);
            begin send_req(bus, addr, 5'(n)); wait_done(1500); end
        join
    endtask

    task automatic clear_cfg();
        ack_dly = 0; poll_wait = 0; nak_idx = -1; al_idx = -1; hang_idx = -1;
    endtask

    initial begin
        clk = 0; rst_n = 0;
        req_valid = 0; req_bus = 0; req_addr = 0; req_len = 0;
        wd_valid = 0; wd_data = 0;
        wbi.ack_i = 0; wbi.dat_i = 0; wbi.irq_i = 0;
        clear_cfg(); cmd_idx = 0; polls = 0; start_ack_cyc = 0; feed_stop = 0;
        fork slave_model(); join_none

        // Outputs held at zero during reset
        repeat (3) @(negedge clk);
        chk("rst_wb", {wbi.cyc_o, wbi.stb_o, wbi.we_o, wbi.adr_o, wbi.dat_o}, 0);
        chk("rst_ctl", {req_ready, wd_ready, done}, 0);
        chk("rst_status", status, 0);

        // Normal two-byte write, including the one-time CSR enable
        push_w(0, 8'hC0);
        tbytes[0] = 8'h44; tbytes[1] = 8'h78;
        push_full(4'd5, 7'h22, 2);
        rst_n = 1;
        run_req(4'd5, 7'h22, 2, -1, 0);
        chk("t1_status", status, 0);
        chk("t1_wd_handshakes", hs_cnt, 2);
        chk("t1_all_writes", exp_q.size(), 0);

        // Address NAK: Stop follows the address command, no data consumed
        nak_idx = 2;
        push_w(1, 8'h05); push_w(2, 8'h06); push_w(2, 8'h04);
        push_w(1, 8'h44); push_w(2, 8'h01); push_w(2, 8'h05);
        run_req(4'd5, 7'h22, 2, -1, 0);
        chk("t2_status", status, 1);
        chk("t2_wd_handshakes", hs_cnt, 0);
        chk("t2_all_writes", exp_q.size(), 0);
        clear_cfg();

        // Arbitration lost after Start: no Stop, then a fresh request without CSR rewrite
        al_idx = 1;
        push_w(1, 8'h05); push_w(2, 8'h06); push_w(2, 8'h04);
        run_req(4'd5, 7'h22, 2, -1, 0);
        chk("t3_status_al", status, 2);
        chk("t3_all_writes", exp_q.size(), 0);
        clear_cfg(); poll_wait = 1;
        tbytes[0] = 8'hA5;
        push_full(4'd3, 7'h51, 1);
        run_req(4'd3, 7'h51, 1, -1, 0);
        chk("t3b_status", status, 0);
        chk("t3b_wd_handshakes", hs_cnt, 1);
        chk("t3b_all_writes", exp_q.size(), 0);
        clear_cfg();

        // Data stall of 20 cycles with slow acks
        ack_dly = 3;
        tbytes[0] = 8'h11; tbytes[1] = 8'h22; tbytes[2] = 8'h33;
        push_full(4'd2, 7'h10, 3);
        run_req(4'd2, 7'h10, 3, 1, 20);
        chk("t5_status", status, 0);
        chk("t5_wd_handshakes", hs_cnt, 3);
        chk("t5_all_writes", exp_q.size(), 0);
        clear_cfg();

        // Start never completes: timeout roughly 50 cycles after its CMDR ack
        hang_idx = 1;
        push_w(1, 8'h05); push_w(2, 8'h06); push_w(2, 8'h04);
        run_req(4'd5, 7'h22, 1, -1, 0);
        chk("t4_status_tmo", status, 4);
        chk("t4_latency_window", (done_cyc - start_ack_cyc >= 48) && (done_cyc - start_ack_cyc <= 60), 1);
        chk("t4_all_writes", exp_q.size(), 0);
        clear_cfg();

        // Reset while a strobe is outstanding
        ack_dly = 3; cmd_idx = 0;
        send_req(4'd1, 7'h7F, 5'd1);
        begin
            int n = 0;
            while (!wbi.stb_o && n < 50) begin @(negedge clk); n++; end
        end
        chk("t6_stb_before_rst", wbi.stb_o, 1);
        #1 rst_n = 0;
        #1;
        chk("t6_rst_wb_drop", {wbi.cyc_o, wbi.stb_o}, 0);
        chk("t6_rst_status", status, 0);
        chk("t6_rst_ready", {req_ready, wd_ready, done}, 0);
        repeat (2) @(negedge clk);
        push_w(0, 8'hC0);
        tbytes[0] = 8'h5A;
        push_full(4'd1, 7'h7F, 1);
        rst_n = 1;
        run_req(4'd1, 7'h7F, 1, -1, 0);
        chk("t6_status", status, 0);
        chk("t6_all_writes", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
